player_plot_scheduler: RTL and testbench
========================================

Name: player_plot_scheduler

Overview:
- Parametrised successor to the fixed four-player draw sequencer that feeds the VGA adapter.
- Round-robins over NUM_PLAYERS position words, emits at most one plot request per player per pass, and holds each request until the pixel writer accepts it (valid/ready).
- Skips dead players and, optionally, players whose position has not changed since their last accepted plot.
- Sits between the move/position logic and the vga_adapter x/y/colour/plot inputs.

Parameters:
- NUM_PLAYERS, 4, number of player channels (1..16).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width.
- SKIP_UNCHANGED, 1, 1 means a player whose position equals its last accepted plot is skipped; 0 means every alive player is plotted every pass.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  allows new passes and new requests
- p_pos  in  NUM_PLAYERS*(X_W+Y_W)  slice i = {x_i, y_i}; x occupies the upper X_W bits
- p_colour  in  NUM_PLAYERS*COLOUR_W  slice i = colour of player i
- p_alive  in  NUM_PLAYERS  1 means player i is eligible to plot
- x  out  X_W  registered plot x
- y  out  Y_W  registered plot y
- colour  out  COLOUR_W  registered plot colour
- plot  out  1  request valid
- plot_ready  in  1  writer accepts when plot && plot_ready
- cur_player  out  clog2(NUM_PLAYERS), minimum 1  index currently scanned or held
- pass_done  out  1  single-cycle pulse after the last index of a pass is resolved

Behaviour:
- States: IDLE, SCAN, PLOT.
- Reset (async, immediate): state = IDLE; cur_player = 0; plot = 0; x = 0; y = 0; colour = 0; pass_done = 0.
- Reset also clears every last-position register and sets every never_plotted flag, so the first pass after reset plots every alive player.
- IDLE:
  - enable = 1 at an edge: go to SCAN with cur_player = 0.
  - enable = 0: stay in IDLE.
- SCAN (one cycle per index):
  - Player i is eligible when p_alive[i] = 1 and (SKIP_UNCHANGED = 0, or never_plotted[i] = 1, or p_pos slice != last_pos[i]).
  - Eligible: at the same edge, latch x, y and colour from the slices, assert plot, go to PLOT.
  - Not eligible: advance the index.
- PLOT:
  - Hold x, y, colour and plot stable while plot_ready = 0. Input changes during the hold must not affect the held outputs.
  - On a handshake edge: last_pos[i] <= latched {x,y}; never_plotted[i] <= 0; plot <= 0; advance the index.
  - Deasserting p_alive or enable during PLOT does not withdraw the request.
- Index advance:
  - i < NUM_PLAYERS-1: cur_player = i+1, state = SCAN.
  - i = NUM_PLAYERS-1: cur_player = 0, pass_done = 1 for exactly one cycle, then state = SCAN if enable = 1, else IDLE.
- Latency:
  - Eligible player: plot is high the cycle after SCAN visits it.
  - Skipped player: costs 1 cycle.
  - Minimum pass length: NUM_PLAYERS cycles when all players are skipped; 2*NUM_PLAYERS cycles when all plot with plot_ready tied high.
- Priority:
  - Reset overrides everything.
  - A handshake completing while enable falls is still recorded.
- The comparison uses the full X_W+Y_W word; colour changes alone do not trigger a replot.
- plot never goes high in IDLE or SCAN.

Test Plan:
- Reset release, enable = 1, plot_ready = 1, all alive, positions {10,20}, {30,40}, {50,60}, {70,80}, colours 1/2/4/6 -> four plots in index order with matching x/y/colour; pass_done pulses once after the 4th handshake.
- Second pass with positions unchanged, SKIP_UNCHANGED = 1 -> no plot for 4 cycles, then pass_done; change only player 2 to {51,61} -> exactly one plot (51,61,4).
- p_alive = 4'b1010 -> only players 1 and 3 plot; cur_player visits 0..3 each pass.
- plot_ready held low for 7 cycles with p_pos changing underneath -> x/y/colour/plot constant for all 7 cycles; accepted on cycle 8; last_pos records the latched value.
- Assert reset while in PLOT -> plot = 0 and cur_player = 0 immediately (asynchronous); the next pass replots every alive player.
- SKIP_UNCHANGED = 0, NUM_PLAYERS = 8, X_W = 9 -> every alive player plots every pass; pass_done pulses once per 8 indices.

Source files
------------

// File: rtl/player_plot_scheduler.sv
// player_plot_scheduler: round-robin plot request sequencer feeding the VGA pixel writer
module player_plot_scheduler #(
  parameter int NUM_PLAYERS    = 4,
  parameter int X_W            = 8,
  parameter int Y_W            = 7,
  parameter int COLOUR_W       = 3,
  parameter int SKIP_UNCHANGED = 1
) (
  input  logic                                               CLOCK_50,
  input  logic                                               reset,
  input  logic                                               enable,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]                   p_pos,
  input  logic [NUM_PLAYERS*COLOUR_W-1:0]                    p_colour,
  input  logic [NUM_PLAYERS-1:0]                             p_alive,
  output logic [X_W-1:0]                                     x,
  output logic [Y_W-1:0]                                     y,
  output logic [COLOUR_W-1:0]                                colour,
  output logic                                               plot,
  input  logic                                               plot_ready,
  output logic [(NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1)-1:0] cur_player,
  output logic                                               pass_done
);
  localparam int P_W   = X_W + Y_W;
  localparam int IDX_W = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, PLOT} state_t;
  state_t                r_state, w_next;
  logic [P_W-1:0]        r_last [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_never;
  logic [P_W-1:0]        w_pos_a [NUM_PLAYERS];
  logic [COLOUR_W-1:0]   w_col_a [NUM_PLAYERS];
  logic                  w_elig, w_last, w_load, w_hs, w_adv;
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_unpack
    assign w_pos_a[i] = p_pos[i*P_W +: P_W];
    assign w_col_a[i] = p_colour[i*COLOUR_W +: COLOUR_W];
  end
  assign w_elig = p_alive[cur_player] &&
                  (SKIP_UNCHANGED == 0 || r_never[cur_player] || w_pos_a[cur_player] != r_last[cur_player]);
  assign w_last = cur_player == IDX_W'(NUM_PLAYERS - 1);
  // State register
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // Next state: a wrap with enable low parks in IDLE, otherwise keep scanning
  always_comb
    w_next = r_state == IDLE ? (enable ? SCAN : IDLE)
           : w_load ? PLOT
           : w_adv ? (w_last && !enable ? IDLE : SCAN)
           : r_state;
  // Output decode: load a request, complete a handshake, or step the index
  always_comb begin
    w_load = r_state == SCAN && w_elig;
    w_hs   = r_state == PLOT && plot_ready;
    w_adv  = (r_state == SCAN && !w_elig) || w_hs;
  end
  // Registered plot outputs, index, and per-player last-plotted memory
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      cur_player <= '0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      pass_done  <= 1'b0;
      r_never    <= '1;
      for (int k = 0; k < NUM_PLAYERS; k++) r_last[k] <= '0;
    end else begin
      pass_done <= w_adv && w_last;
      if (w_adv) cur_player <= w_last ? '0 : cur_player + 1'b1;
      if (w_load) begin
        {x, y} <= w_pos_a[cur_player];
        colour <= w_col_a[cur_player];
        plot   <= 1'b1;
      end
      if (w_hs) begin
        r_last[cur_player]  <= {x, y};
        r_never[cur_player] <= 1'b0;
        plot                <= 1'b0;
      end
    end
endmodule

// File: tb/tb_player_plot_scheduler.sv
// tb_player_plot_scheduler: directed scoreboard bench for the plot scheduler
module tb_player_plot_scheduler;
  logic clk = 0, rst = 1, en = 0, rdy = 0;
  logic [59:0] p_pos;
  logic [11:0] p_col;
  logic [3:0]  alive = 4'hF;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, pass_done;
  logic [1:0]  cur;
  logic [7:0]  bx [4];
  logic [6:0]  by [4];
  logic [2:0]  bc [4];
  logic         rst2 = 1;
  logic [127:0] pos2;
  logic [23:0]  col2;
  logic [7:0]   alive2 = 8'b1101_1011;
  logic [8:0]   x2;
  logic [6:0]   y2;
  logic [2:0]   c2;
  logic         plot2, pd2;
  logic [2:0]   cur2;
  logic [8:0]   bx2 [8];
  logic [6:0]   by2 [8];
  logic [2:0]   bc2 [8];
  logic [31:0]  q[$], q2[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 4; i++) begin
      p_pos[i*15 +: 15] = {bx[i], by[i]};
      p_col[i*3 +: 3]   = bc[i];
    end

  always_comb
    for (int i = 0; i < 8; i++) begin
      pos2[i*16 +: 16] = {bx2[i], by2[i]};
      col2[i*3 +: 3]   = bc2[i];
    end

  player_plot_scheduler dut (
    .CLOCK_50(clk), .reset(rst), .enable(en), .p_pos(p_pos), .p_colour(p_col),
    .p_alive(alive), .x(x), .y(y), .colour(colour), .plot(plot),
    .plot_ready(rdy), .cur_player(cur), .pass_done(pass_done)
  );

  player_plot_scheduler #(.NUM_PLAYERS(8), .X_W(9), .Y_W(7), .COLOUR_W(3), .SKIP_UNCHANGED(0)) dut8 (
    .CLOCK_50(clk), .reset(rst2), .enable(1'b1), .p_pos(pos2), .p_colour(col2),
    .p_alive(alive2), .x(x2), .y(y2), .colour(c2), .plot(plot2),
    .plot_ready(1'b1), .cur_player(cur2), .pass_done(pd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int i);
    q.push_back({14'd0, bx[i], by[i], bc[i]});
  endfunction

  function automatic void push2(input int i);
    q2.push_back({13'd0, bx2[i], by2[i], bc2[i]});
  endfunction

  task automatic sample(input string tag);
    logic [31:0] e;
    if (plot && rdy) begin
      e = q.size() != 0 ? q.pop_front() : 'x;
      chk(tag, {14'd0, x, y, colour}, e);
    end
  endtask

  task automatic run_pass(input string tag, output int cyc, output logic [3:0] seen);
    logic pd;
    cyc = 0; seen = '0; pd = 1'b0;
    while (!pd && cyc < 64) begin
      @(negedge clk);
      cyc++;
      seen[cur] = 1'b1;
      sample({tag, ":plot"});
      pd = pass_done;
    end
    chk({tag, ":pass_done"}, {31'd0, pd}, 1);
    chk({tag, ":drained"}, q.size(), 0);
  endtask

  task automatic run_pass8(input string tag, output int cyc);
    logic pd;
    logic [31:0] e;
    cyc = 0; pd = 1'b0;
    while (!pd && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (plot2) begin
        e = q2.size() != 0 ? q2.pop_front() : 'x;
        chk({tag, ":plot"}, {13'd0, x2, y2, c2}, e);
      end
      pd = pd2;
    end
    chk({tag, ":pass_done"}, {31'd0, pd}, 1);
    chk({tag, ":drained"}, q2.size(), 0);
  endtask

  initial begin
    int cyc, k;
    logic [3:0] seen;
    logic [31:0] e0;
    bx = '{8'd10, 8'd30, 8'd50, 8'd70};
    by = '{7'd20, 7'd40, 7'd60, 7'd80};
    bc = '{3'd1, 3'd2, 3'd4, 3'd6};
    for (int i = 0; i < 8; i++) begin
      bx2[i] = 9'(300 + i);
      by2[i] = 7'(i * 10 + 5);
      bc2[i] = 3'(i);
    end
    repeat (3) @(negedge clk);
    chk("reset", {17'd0, plot, pass_done, cur, x, y, colour}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle", {29'd0, plot, pass_done, cur}, 0);

    en = 1; rdy = 1;
    for (int i = 0; i < 4; i++) push(i);
    run_pass("p1", cyc, seen);
    chk("p1:len", cyc, 9);
    run_pass("p2_skip", cyc, seen);
    chk("p2:len", cyc, 4);
    @(negedge clk);
    chk("pd_once", {31'd0, pass_done}, 0);
    run_pass("p2b_skip", cyc, seen);
    bx[2] = 8'd51; by[2] = 7'd61; push(2);
    run_pass("p3", cyc, seen);
    chk("p3:len", cyc, 5);

    alive = 4'b1010;
    for (int i = 0; i < 4; i++) bx[i] = bx[i] + 8'd1;
    push(1); push(3);
    run_pass("p4_alive", cyc, seen);
    chk("p4:len", cyc, 6);
    chk("p4:visit", {28'd0, seen}, 32'hF);
    alive = 4'hF;
    push(0); push(2);
    run_pass("p5", cyc, seen);
    chk("p5:len", cyc, 6);

    rdy = 0;
    bx[0] = 8'd100; by[0] = 7'd100; bc[0] = 3'd5;
    e0 = {14'd0, 8'd100, 7'd100, 3'd5};
    push(0);
    k = 0;
    while (!plot && k < 10) begin @(negedge clk); k++; end
    for (int i = 0; i < 7; i++) begin
      chk("hold", {13'd0, plot, x, y, colour}, e0 | 32'h40000);
      bx[0] = 8'(i * 7 + 3); by[0] = 7'(i + 1); bc[0] = 3'(i);
      @(negedge clk);
    end
    chk("hold8", {31'd0, plot}, 1);
    bx[0] = 8'd100; by[0] = 7'd100; bc[0] = 3'd5;
    rdy = 1;
    sample("hold_accept");
    run_pass("p6", cyc, seen);
    chk("p6:len", cyc, 4);
    run_pass("p7_last", cyc, seen);
    chk("p7:len", cyc, 4);

    rdy = 0;
    bx[1] = 8'd7;
    k = 0;
    while (!plot && k < 10) begin @(negedge clk); k++; end
    chk("rst_plot_pre", {31'd0, plot}, 1);
    #1 rst = 1;
    #1 chk("async_rst", {17'd0, plot, pass_done, cur, x, y, colour}, 0);
    @(negedge clk);
    rst = 0; rdy = 1;
    for (int i = 0; i < 4; i++) push(i);
    run_pass("p8_rst", cyc, seen);
    chk("p8:len", cyc, 9);

    en = 0;
    run_pass("p9_off", cyc, seen);
    chk("p9:len", cyc, 4);
    bx[3] = 8'd200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_hold", {29'd0, plot, pass_done, cur}, 0);
    end

    rst2 = 0;
    for (int i = 0; i < 8; i++) if (alive2[i]) push2(i);
    run_pass8("n8_p1", cyc);
    chk("n8_p1:len", cyc, 15);
    for (int i = 0; i < 8; i++) if (alive2[i]) push2(i);
    run_pass8("n8_p2", cyc);
    chk("n8_p2:len", cyc, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
